// File: rtl/pipeline_hazard_ctrl_if.sv
// ---- pipeline_hazard_ctrl_if : ID/EX hazard inputs and pipeline control outputs ---- Rev 1.0
`default_nettype none

interface pipeline_hazard_ctrl_if;
  logic [4:0] id_rs1;
  logic [4:0] id_rs2;
  logic       id_uses_rs1;
  logic       id_uses_rs2;
  logic [4:0] ex_rd;
  logic       ex_memtoreg;
  logic       ex_regwrite;
  logic [3:0] ex_mul_div_op;
  logic       ex_branch_taken;

  logic       pc_stall;
  logic       ifid_stall;
  logic       ifid_flush;
  logic       idex_hold;
  logic       idex_flush;
  logic       exmem_bubble;
  logic       md_start;
  logic       md_busy;
  logic       md_result_valid;

  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_memtoreg,
           ex_regwrite, ex_mul_div_op, ex_branch_taken,
    input  pc_stall, ifid_stall, ifid_flush, idex_hold, idex_flush,
           exmem_bubble, md_start, md_busy, md_result_valid
  );

  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_rd, ex_memtoreg,
           ex_regwrite, ex_mul_div_op, ex_branch_taken,
    output pc_stall, ifid_stall, ifid_flush, idex_hold, idex_flush,
           exmem_bubble, md_start, md_busy, md_result_valid
  );
endinterface

`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
// ---- pipeline_hazard_ctrl : load-use / branch / mul-div sequencing control ---- Rev 1.0
`default_nettype none

module pipeline_hazard_ctrl #(
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 33
) (
  input  wire logic clk,
  input  wire logic reset,
  pipeline_hazard_ctrl_if.slave hz
);

  localparam logic [5:0] C_MUL_LOAD = 6'(MUL_LAT - 1);
  localparam logic [5:0] C_DIV_LOAD = 6'(DIV_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     r_state;
  logic [5:0] r_cnt;

  logic w_op_valid;
  logic w_start;
  logic w_rs1_hit;
  logic w_rs2_hit;
  logic w_load_use;

  // Ops 8..15 all have bit 3 set and are treated as "no op".
  assign w_op_valid = ~hz.ex_mul_div_op[3];
  assign w_start    = (r_state == S_IDLE) && w_op_valid && !hz.ex_branch_taken;

  assign w_rs1_hit  = hz.id_uses_rs1 && (hz.id_rs1 == hz.ex_rd);
  assign w_rs2_hit  = hz.id_uses_rs2 && (hz.id_rs2 == hz.ex_rd);
  assign w_load_use = (r_state == S_IDLE) && !w_start &&
                      hz.ex_memtoreg && hz.ex_regwrite && (hz.ex_rd != 5'd0) &&
                      (w_rs1_hit || w_rs2_hit);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 6'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_state <= S_RUN;
            r_cnt   <= hz.ex_mul_div_op[2] ? C_DIV_LOAD : C_MUL_LOAD;
          end
        end
        S_RUN: begin
          if (r_cnt == 6'd0) begin
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt - 6'd1;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A taken branch suppresses every other control so the flush wins cleanly.
  always_comb begin
    hz.pc_stall        = 1'b0;
    hz.ifid_stall      = 1'b0;
    hz.ifid_flush      = 1'b0;
    hz.idex_hold       = 1'b0;
    hz.idex_flush      = 1'b0;
    hz.exmem_bubble    = 1'b0;
    hz.md_start        = 1'b0;
    hz.md_busy         = 1'b0;
    hz.md_result_valid = 1'b0;
    if (hz.ex_branch_taken) begin
      hz.ifid_flush = 1'b1;
      hz.idex_flush = 1'b1;
    end else if (w_start || (r_state == S_RUN)) begin
      hz.md_start     = w_start;
      hz.md_busy      = 1'b1;
      hz.pc_stall     = 1'b1;
      hz.ifid_stall   = 1'b1;
      hz.idex_hold    = 1'b1;
      hz.exmem_bubble = 1'b1;
    end else if (r_state == S_DONE) begin
      hz.md_result_valid = 1'b1;
    end else if (w_load_use) begin
      hz.pc_stall   = 1'b1;
      hz.ifid_stall = 1'b1;
      hz.idex_flush = 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---- tb_pipeline_hazard_ctrl : directed and randomized checks against a cycle-count model ---- Rev 1.0
`default_nettype none

module tb_pipeline_hazard_ctrl;

  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 33;

  // Output vector order: pc_stall ifid_stall ifid_flush idex_hold idex_flush exmem_bubble md_start md_busy md_result_valid
  localparam logic [8:0] C_NONE   = 9'b000000000;
  localparam logic [8:0] C_BRANCH = 9'b001010000;
  localparam logic [8:0] C_START  = 9'b110101110;
  localparam logic [8:0] C_RUN    = 9'b110101010;
  localparam logic [8:0] C_DONE   = 9'b000000001;
  localparam logic [8:0] C_LU     = 9'b110010000;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  // Model: a sequence is described only by its start cycle and latency.
  int m_cyc = 0;
  int m_start = -1;
  int m_lat = 0;

  pipeline_hazard_ctrl_if hz ();

  pipeline_hazard_ctrl #(
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .hz   (hz.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [8:0] dut_outs();
    return {hz.pc_stall, hz.ifid_stall, hz.ifid_flush, hz.idex_hold, hz.idex_flush,
            hz.exmem_bubble, hz.md_start, hz.md_busy, hz.md_result_valid};
  endfunction

  function automatic bit model_active();
    return (m_start >= 0) && (m_cyc > m_start) && (m_cyc <= m_start + m_lat + 1);
  endfunction

  function automatic logic [8:0] model_outs();
    bit run, done, idle, start, lu;
    run   = (m_start >= 0) && (m_cyc > m_start) && (m_cyc <= m_start + m_lat);
    done  = (m_start >= 0) && (m_cyc == m_start + m_lat + 1);
    idle  = !run && !done;
    start = idle && (hz.ex_mul_div_op < 4'd8) && !hz.ex_branch_taken;
    lu    = idle && hz.ex_memtoreg && hz.ex_regwrite && (hz.ex_rd != 5'd0) &&
            ((hz.id_uses_rs1 && hz.id_rs1 == hz.ex_rd) || (hz.id_uses_rs2 && hz.id_rs2 == hz.ex_rd));
    if (hz.ex_branch_taken) return C_BRANCH;
    if (start)              return C_START;
    if (run)                return C_RUN;
    if (done)               return C_DONE;
    if (lu)                 return C_LU;
    return C_NONE;
  endfunction

  task automatic tick();
    logic [8:0] e;
    logic [3:0] op;
    e  = model_outs();
    op = hz.ex_mul_div_op;
    @(posedge clk);
    if (reset) begin
      m_start = -1;
    end else if (e[2]) begin
      m_start = m_cyc;
      m_lat   = (op >= 4'd4) ? DIV_LAT : MUL_LAT;
    end
    m_cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    hz.id_rs1 = 5'd0;  hz.id_rs2 = 5'd0;
    hz.id_uses_rs1 = 1'b0;  hz.id_uses_rs2 = 1'b0;
    hz.ex_rd = 5'd0;  hz.ex_memtoreg = 1'b0;  hz.ex_regwrite = 1'b0;
    hz.ex_mul_div_op = 4'hF;  hz.ex_branch_taken = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rd, input logic [4:0] rs1, input logic u1,
                              input logic [4:0] rs2, input logic u2);
    hz.ex_memtoreg = 1'b1;  hz.ex_regwrite = 1'b1;  hz.ex_rd = rd;
    hz.id_rs1 = rs1;  hz.id_uses_rs1 = u1;
    hz.id_rs2 = rs2;  hz.id_uses_rs2 = u2;
  endtask

  task automatic test_reset();
    logic [8:0] obs;
    idle_inputs();
    reset = 1'b1;
    tick(); tick();
    #1 obs = dut_outs();
    n_checks++;
    if (obs !== C_NONE) begin n_fail++; $display("FAIL reset_idle: got %b expected %b", obs, C_NONE); end
    set_load_use(5'd7, 5'd7, 1'b1, 5'd0, 1'b0);
    #1 obs = dut_outs();
    n_checks++;
    if (obs !== C_LU) begin n_fail++; $display("FAIL reset_comb_lu: got %b expected %b", obs, C_LU); end
    tick();
    reset = 1'b0;
    idle_inputs();
    #1 obs = dut_outs();
    n_checks++;
    if (obs !== C_NONE) begin n_fail++; $display("FAIL reset_release: got %b expected %b", obs, C_NONE); end
    tick();
  endtask

  task automatic test_load_use();
    logic [8:0] obs;
    set_load_use(5'd5, 5'd5, 1'b1, 5'd1, 1'b1);
    #1 obs = dut_outs();
    n_checks++;
    if (obs !== C_LU) begin n_fail++; $display("FAIL lu_rs1: got %b expected %b", obs, C_LU); end
    tick();
    // Bubble now in EX, dependent add still in ID.
    hz.ex_memtoreg = 1'b0;  hz.ex_regwrite = 1'b0;  hz.ex_rd = 5'd0;
    #1 obs = dut_outs();
    n_checks++;
    if (obs !== C_NONE) begin n_fail++; $display("FAIL lu_release: got %b expected %b", obs, C_NONE); end
    tick();
    set_load_use(5'd0, 5'd0, 1'b1, 5'd0, 1'b1);
    #1 obs = dut_outs();
    n_checks++;
    if (obs !== C_NONE) begin n_fail++; $display("FAIL lu_rd_zero: got %b expected %b", obs, C_NONE); end
    tick();
    set_load_use(5'd9, 5'd3, 1'b1, 5'd9, 1'b1);
    #1 obs = dut_outs();
    n_checks++;
    if (obs !== C_LU) begin n_fail++; $display("FAIL lu_rs2: got %b expected %b", obs, C_LU); end
    tick();
    set_load_use(5'd9, 5'd9, 1'b0, 5'd9, 1'b0);
    #1 obs = dut_outs();
    n_checks++;
    if (obs !== C_NONE) begin n_fail++; $display("FAIL lu_unused_regs: got %b expected %b", obs, C_NONE); end
    tick();
    set_load_use(5'd9, 5'd9, 1'b1, 5'd0, 1'b0);
    hz.ex_regwrite = 1'b0;
    #1 obs = dut_outs();
    n_checks++;
    if (obs !== C_NONE) begin n_fail++; $display("FAIL lu_no_regwrite: got %b expected %b", obs, C_NONE); end
    tick();
    idle_inputs();
  endtask

  task automatic test_mul();
    logic [8:0] obs, exp;
    idle_inputs();
    for (int k = 0; k <= MUL_LAT + 2; k++) begin
      hz.ex_mul_div_op = (k <= MUL_LAT + 1) ? 4'd0 : 4'hF;
      exp = (k == 0) ? C_START : (k <= MUL_LAT) ? C_RUN : (k == MUL_LAT + 1) ? C_DONE : C_NONE;
      #1 obs = dut_outs();
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL mul_seq k=%0d: got %b expected %b", k, obs, exp); end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] obs, exp;
    int t0;
    idle_inputs();
    t0 = DIV_LAT + 2;
    for (int k = 0; k < t0 + MUL_LAT + 3; k++) begin
      if (k < t0)                    hz.ex_mul_div_op = 4'd4;
      else if (k <= t0 + MUL_LAT + 1) hz.ex_mul_div_op = 4'd0;
      else                           hz.ex_mul_div_op = 4'hF;
      if (k == 0)                      exp = C_START;
      else if (k <= DIV_LAT)           exp = C_RUN;
      else if (k == DIV_LAT + 1)       exp = C_DONE;
      else if (k == t0)                exp = C_START;
      else if (k <= t0 + MUL_LAT)      exp = C_RUN;
      else if (k == t0 + MUL_LAT + 1)  exp = C_DONE;
      else                             exp = C_NONE;
      #1 obs = dut_outs();
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL b2b k=%0d: got %b expected %b", k, obs, exp); end
      tick();
    end
  endtask

  task automatic test_branch();
    logic [8:0] obs;
    idle_inputs();
    set_load_use(5'd5, 5'd5, 1'b1, 5'd0, 1'b0);
    hz.ex_branch_taken = 1'b1;
    #1 obs = dut_outs();
    n_checks++;
    if (obs !== C_BRANCH) begin n_fail++; $display("FAIL branch_over_lu: got %b expected %b", obs, C_BRANCH); end
    tick();
    idle_inputs();
    hz.ex_branch_taken = 1'b1;
    hz.ex_mul_div_op = 4'd2;
    #1 obs = dut_outs();
    n_checks++;
    if (obs !== C_BRANCH) begin n_fail++; $display("FAIL branch_over_md: got %b expected %b", obs, C_BRANCH); end
    tick();
    idle_inputs();
    #1 obs = dut_outs();
    n_checks++;
    if (obs !== C_NONE) begin n_fail++; $display("FAIL branch_no_start: got %b expected %b", obs, C_NONE); end
    tick();
  endtask

  task automatic test_invalid_op();
    logic [8:0] obs;
    idle_inputs();
    for (int op = 8; op <= 14; op++) begin
      hz.ex_mul_div_op = 4'(op);
      #1 obs = dut_outs();
      n_checks++;
      if (obs !== C_NONE) begin n_fail++; $display("FAIL invalid_op %0d: got %b expected %b", op, obs, C_NONE); end
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_reset_midrun();
    logic [8:0] obs, exp;
    idle_inputs();
    hz.ex_mul_div_op = 4'd4;
    for (int k = 0; k < 13; k++) tick();
    // Counter is at 20 here; abort the divide.
    reset = 1'b1;
    hz.ex_mul_div_op = 4'hF;
    tick();
    reset = 1'b0;
    for (int k = 0; k < DIV_LAT + 8; k++) begin
      #1 obs = dut_outs();
      n_checks++;
      if (obs !== C_NONE) begin n_fail++; $display("FAIL abort k=%0d: got %b expected %b", k, obs, C_NONE); end
      tick();
    end
    hz.ex_mul_div_op = 4'd4;
    for (int k = 0; k <= DIV_LAT + 1; k++) begin
      exp = (k == 0) ? C_START : (k <= DIV_LAT) ? C_RUN : C_DONE;
      #1 obs = dut_outs();
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL restart k=%0d: got %b expected %b", k, obs, exp); end
      tick();
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    logic [8:0] obs, exp;
    for (int k = 0; k < 600; k++) begin
      hz.id_rs1 = 5'($urandom_range(0, 3));
      hz.id_rs2 = 5'($urandom_range(0, 3));
      hz.id_uses_rs1 = 1'($urandom);
      hz.id_uses_rs2 = 1'($urandom);
      hz.ex_rd = 5'($urandom_range(0, 3));
      hz.ex_memtoreg = 1'($urandom);
      hz.ex_regwrite = 1'($urandom);
      hz.ex_mul_div_op = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'hF;
      hz.ex_branch_taken = model_active() ? 1'b0 : ($urandom_range(0, 5) == 0);
      reset = ($urandom_range(0, 60) == 0);
      #1 obs = dut_outs();
      exp = model_outs();
      n_checks++;
      if (obs !== exp) begin n_fail++; $display("FAIL random k=%0d: got %b expected %b", k, obs, exp); end
      tick();
    end
    reset = 1'b0;
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    #1;
    test_reset();
    test_load_use();
    test_mul();
    test_back_to_back();
    test_branch();
    test_invalid_op();
    test_reset_midrun();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Hazard and sequencing controller for the 5-stage RV32I pipeline. It sits alongside the IF/ID and ID/EX pipeline registers. It detects load-use hazards and taken-branch redirects, and it sequences the multi-cycle multiply/divide unit occupying EX. It drives the stall, hold, flush and bubble controls for PC, IF/ID, ID/EX and EX/MEM. It also drives the start pulse for the mul/div unit.

## Interface
Parameters:
- MUL_LAT, 3, busy cycles for mul ops (1..63)
- DIV_LAT, 33, busy cycles for div/rem ops (1..63)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- id_rs1  in  5  rs1 of instruction in ID
- id_rs2  in  5  rs2 of instruction in ID
- id_uses_rs1  in  1  ID instruction reads rs1
- id_uses_rs2  in  1  ID instruction reads rs2
- ex_rd  in  5  rd of instruction in EX (ID/EX output)
- ex_memtoreg  in  1  EX instruction is a load
- ex_regwrite  in  1  EX instruction writes rd
- ex_mul_div_op  in  4  EX mul/div op; 0-3 mul, 4-7 div/rem, 4'b1111 none, 8-14 treated as none
- ex_branch_taken  in  1  EX resolved a taken branch/jump
- pc_stall  out  1  hold PC
- ifid_stall  out  1  hold IF/ID
- ifid_flush  out  1  zero IF/ID next edge
- idex_hold  out  1  hold ID/EX contents
- idex_flush  out  1  load bubble (reset values) into ID/EX next edge
- exmem_bubble  out  1  load bubble into EX/MEM next edge
- md_start  out  1  one-cycle start pulse to mul/div unit
- md_busy  out  1  mul/div sequence in progress
- md_result_valid  out  1  mul/div result valid on EX output this cycle

## Operation
- Mul/div FSM states: IDLE, RUN, DONE. Down-counter cnt is 6 bits.
- IDLE, with a valid op (0-7) in EX and ex_branch_taken=0:
  - md_start=1; pc_stall, ifid_stall, idex_hold, exmem_bubble=1 in the same cycle (combinational).
  - Next state RUN, cnt loaded with LAT-1. LAT is MUL_LAT for ops 0-3 and DIV_LAT for ops 4-7.
- RUN: stalls, idex_hold, exmem_bubble and md_busy asserted.
  - cnt>0: decrement.
  - cnt==0: go to DONE.
- DONE (one cycle): md_result_valid=1; all stalls released; ID/EX advances at the cycle end. Next state IDLE.
  - A mul/div op entering EX next cycle starts a new sequence immediately (back-to-back).
- md_busy=1 in the start cycle and in RUN; 0 in IDLE and DONE.
- Load-use hazard, evaluated only when FSM is IDLE and no mul/div start this cycle:
  - Condition: ex_memtoreg & ex_regwrite & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
  - Response: pc_stall=1, ifid_stall=1, idex_flush=1 for exactly one cycle.
- Taken branch (ex_branch_taken=1): ifid_flush=1, idex_flush=1; pc_stall=0, ifid_stall=0.
- Priority: branch flush > mul/div sequencing > load-use.
  - Branch and load-use in the same cycle: flush only.
  - idex_hold and idex_flush are never both 1.
- Output-asserting cases:

  | Case | Outputs = 1 |
  |---|---|
  | Mul/div start cycle | md_start, md_busy, pc_stall, ifid_stall, idex_hold, exmem_bubble |
  | RUN | md_busy, pc_stall, ifid_stall, idex_hold, exmem_bubble |
  | DONE | md_result_valid |
  | Load-use | pc_stall, ifid_stall, idex_flush |
  | Branch taken | ifid_flush, idex_flush |

  Every output not listed for a case is 0; with no case active, all outputs are 0.

## Timing
- Reset: FSM=IDLE, cnt=0. After a reset edge, the FSM state drives no outputs. Outputs that depend only on the FSM state (md_busy while in RUN, md_result_valid) are 0; inputs still drive the combinational outputs.
- Reset mid-RUN aborts the sequence; no md_result_valid is produced. The mul/div unit is reset by the same signal.
- Mul/div op reaching EX at cycle T:
  - Stall asserted in cycles T..T+LAT.
  - DONE / md_result_valid at cycle T+LAT+1.
  - Total EX occupancy LAT+2 cycles.
- Load-use: 1-cycle bubble. The dependent instruction enters EX two cycles after the load did.
- All outputs are combinational from the FSM state and the current inputs; there are no registered outputs besides the FSM state and cnt.

## Test plan
- Reset asserted during RUN of DIV_LAT=33 at cnt=20 -> next cycle all outputs 0, no md_result_valid ever; later op 4 starts a fresh 33-cycle sequence.
- lw x5 in EX, add x6,x5,x1 in ID (id_uses_rs1, id_rs1=5) -> pc_stall=ifid_stall=idex_flush=1 for one cycle; the next cycle has no stall.
- Load with ex_rd=0 and matching id_rs1=0 -> no stall.
- mul (op 0), MUL_LAT=3, enters EX at T=10 -> md_start only at 10; stalls/idex_hold/exmem_bubble 10..13; md_result_valid at 14; md_busy 10..13.
- div (op 4) immediately followed by mul (op 0), defaults -> div stall 0..33, DONE 34; mul md_start at 35, DONE 39.
- ex_branch_taken=1 coinciding with a load-use match -> ifid_flush=idex_flush=1, pc_stall=0.
- ex_mul_div_op=4'b1010 -> treated as none; no md_start, no stall.
